imem_boot_loader: RTL and testbench

- Parametrised instruction-memory subsystem for the pipelined core: dual-use instruction RAM with a handshaked bulk-load port and a registered fetch port.
- Replaces the single-word write path (write-enable, data, address per cycle) with a boot FSM that streams a programme of arbitrary length from a base address, checksums it and gates the core's reset.
- Holds the core in reset while loading and releases it once the load completes.

---
 rtl/imem_boot_loader.sv | 145 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Instruction RAM with a streaming boot loader and fetch port.
// Ports: clock/reset, load_* stream in, run_start, fetch_* out, core_reset_n.
module imem_boot_loader #(
  parameter int PC_SIZE       = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH     = 1024,
  parameter int RELEASE_DELAY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [PC_SIZE-1:0]    load_base,
  input  logic [PC_SIZE:0]      load_len,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  input  logic                  run_start,
  output logic                  load_done,
  output logic                  load_error,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  core_reset_n,
  output logic                  busy,
  input  logic [PC_SIZE-1:0]    fetch_pc,
  output logic [DATA_WIDTH-1:0] fetch_instr,
  output logic                  fetch_valid
);

  localparam int AW = PC_SIZE + 1;
  localparam logic [AW-1:0] DEPTH = AW'(MEM_DEPTH);
  localparam logic [3:0] DLY_LAST = 4'(RELEASE_DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_RUN
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [AW-1:0]         r_addr;
  logic [AW-1:0]         r_rem;
  logic [DATA_WIDTH-1:0] r_sum;
  logic                  r_err;
  logic [3:0]            r_dly;
  logic [DATA_WIDTH-1:0] r_fetch;
  logic                  r_fvalid;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic w_start;
  logic w_ready;
  logic w_xfer;
  logic w_in_range;
  logic w_pc_ok;
  logic w_run;

  assign w_run      = (r_state == S_RUN);
  assign w_start    = load_start &&
                      (r_state == S_IDLE || w_run);
  assign w_ready    = (r_state == S_LOAD) && (r_rem != '0);
  assign w_xfer     = w_ready && load_valid;
  assign w_in_range = (r_addr < DEPTH);
  assign w_pc_ok    = ({1'b0, fetch_pc} < DEPTH);

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // After the last word the FSM lingers one cycle in LOAD
  // with rem==0; that cycle is the load_done pulse.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (load_start)     w_next = S_LOAD;
        else if (run_start) w_next = S_DRAIN;
      end
      S_LOAD: begin
        if (r_rem == '0) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_dly == DLY_LAST) w_next = S_RUN;
      end
      S_RUN: begin
        if (load_start) w_next = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_sum  <= '0;
      r_err  <= 1'b0;
    end else if (w_start) begin
      r_addr <= {1'b0, load_base};
      r_rem  <= load_len;
      r_sum  <= '0;
      r_err  <= 1'b0;
    end else if (w_xfer) begin
      r_rem <= r_rem - 1'b1;
      r_sum <= r_sum + load_data;
      // Saturate once out of range so the address never wraps.
      if (w_in_range) r_addr <= r_addr + 1'b1;
      else            r_err  <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset)                  r_dly <= '0;
    else if (r_state == S_DRAIN) r_dly <= r_dly + 1'b1;
    else                         r_dly <= '0;
  end

  always_ff @(posedge clock) begin
    if (reset && w_xfer && w_in_range)
      r_mem[r_addr[PC_SIZE-1:0]] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fetch  <= '0;
      r_fvalid <= 1'b0;
    end else if (w_run && !load_start) begin
      r_fetch  <= w_pc_ok ? r_mem[fetch_pc] : '0;
      r_fvalid <= 1'b1;
    end else begin
      r_fetch  <= '0;
      r_fvalid <= 1'b0;
    end
  end

  assign load_ready   = w_ready;
  assign load_done    = (r_state == S_LOAD) && (r_rem == '0);
  assign load_error   = r_err;
  assign checksum     = r_sum;
  assign core_reset_n = w_run;
  assign busy         = (r_state == S_LOAD) ||
                        (r_state == S_DRAIN);
  assign fetch_instr  = r_fetch;
  assign fetch_valid  = r_fvalid;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader.
// Scoreboard queues hold expected fetch words and checksums.
module tb_imem_boot_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic [9:0]  load_base = '0;
  logic [10:0] load_len = '0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ready;
  logic        run_start = 1'b0;
  logic        load_done;
  logic        load_error;
  logic [31:0] checksum;
  logic        core_reset_n;
  logic        busy;
  logic [9:0]  fetch_pc = '0;
  logic [31:0] fetch_instr;
  logic        fetch_valid;

  imem_boot_loader #(
    .PC_SIZE(10), .DATA_WIDTH(32),
    .MEM_DEPTH(1024), .RELEASE_DELAY(2)
  ) dut (
    .clock(clock), .reset(reset),
    .load_start(load_start), .load_base(load_base),
    .load_len(load_len), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready),
    .run_start(run_start), .load_done(load_done),
    .load_error(load_error), .checksum(checksum),
    .core_reset_n(core_reset_n), .busy(busy),
    .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .fetch_valid(fetch_valid)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mdl [1024];
  logic [31:0] words [8];
  logic [31:0] q_fetch [$];
  logic [31:0] q_sum [$];
  logic        exp_err;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ready"}, 32'(load_ready), 0);
    chk({tag, "_done"}, 32'(load_done), 0);
    chk({tag, "_err"}, 32'(load_error), 0);
    chk({tag, "_sum"}, checksum, 0);
    chk({tag, "_crst"}, 32'(core_reset_n), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_finstr"}, fetch_instr, 0);
    chk({tag, "_fvalid"}, 32'(fetch_valid), 0);
  endtask

  task automatic fetch(input int pc);
    logic [31:0] e;
    fetch_pc = 10'(pc);
    q_fetch.push_back(mdl[pc]);
    tick();
    e = q_fetch.pop_front();
    chk("fetch_valid", 32'(fetch_valid), 1);
    chk($sformatf("fetch_%0d", pc), fetch_instr, e);
  endtask

  task automatic drain_to_run(input string tag);
    chk({tag, "_drain1_crst"}, 32'(core_reset_n), 0);
    chk({tag, "_drain1_busy"}, 32'(busy), 1);
    tick();
    chk({tag, "_drain2_crst"}, 32'(core_reset_n), 0);
    tick();
    chk({tag, "_run_crst"}, 32'(core_reset_n), 1);
    chk({tag, "_run_busy"}, 32'(busy), 0);
    chk({tag, "_run_fvalid"}, 32'(fetch_valid), 0);
  endtask

  task automatic do_load(input string tag, input int base,
                         input int len, input bit toggle);
    int sent;
    int cyc;
    int addr;
    logic [31:0] sum;
    sent = 0;
    cyc = 0;
    addr = base;
    sum = '0;
    exp_err = 1'b0;
    load_start = 1'b1;
    load_base = 10'(base);
    load_len = 11'(len);
    tick();
    load_start = 1'b0;
    chk({tag, "_start_crst"}, 32'(core_reset_n), 0);
    chk({tag, "_start_fvalid"}, 32'(fetch_valid), 0);
    chk({tag, "_start_err"}, 32'(load_error), 0);
    chk({tag, "_start_sum"}, checksum, 0);
    chk({tag, "_start_busy"}, 32'(busy), 1);
    while (sent < len && cyc < 200) begin
      load_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      load_data = words[sent];
      chk({tag, "_ready"}, 32'(load_ready), 1);
      chk({tag, "_done_early"}, 32'(load_done), 0);
      if (load_valid) begin
        if (addr < 1024) mdl[addr] = load_data;
        else exp_err = 1'b1;
        sum = sum + load_data;
        addr++;
        sent++;
      end
      tick();
      cyc++;
    end
    load_valid = 1'b0;
    chk({tag, "_sent"}, 32'(sent), 32'(len));
    q_sum.push_back(sum);
    chk({tag, "_done"}, 32'(load_done), 1);
    chk({tag, "_ready_end"}, 32'(load_ready), 0);
    chk({tag, "_sum"}, checksum, q_sum.pop_front());
    chk({tag, "_err"}, 32'(load_error), 32'(exp_err));
    tick();
    chk({tag, "_done_once"}, 32'(load_done), 0);
    drain_to_run(tag);
  endtask

  initial begin
    reset = 1'b0;
    tick();
    tick();
    chk_rst("reset");
    reset = 1'b1;
    tick();

    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    words[2] = 32'h0020_8113;
    words[3] = 32'hFFFF_FFFF;
    do_load("cont", 0, 4, 1'b0);
    fetch(2);
    fetch(0);
    fetch(3);

    do_load("toggle", 0, 4, 1'b1);
    fetch(1);
    fetch(2);

    words[0] = 32'hA5A5_0001;
    words[1] = 32'hA5A5_0002;
    words[2] = 32'hA5A5_0003;
    words[3] = 32'hA5A5_0004;
    do_load("edge", 1022, 4, 1'b0);
    fetch(1022);
    fetch(1023);
    fetch(0);

    words[0] = 32'h1234_5678;
    words[1] = 32'h9ABC_DEF0;
    words[2] = 32'h0BAD_F00D;
    do_load("reload", 8, 3, 1'b0);
    fetch(8);
    fetch(9);
    fetch(10);

    do_load("zero", 0, 0, 1'b0);
    fetch(9);

    reset = 1'b0;
    tick();
    chk_rst("reset2");
    reset = 1'b1;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    drain_to_run("runonly");
    fetch(8);
    fetch(1);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    load_start = 1'b1;
    load_base = 10'd100;
    load_len = 11'd5;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data = 32'hCAFE_0000;
    mdl[100] = load_data;
    tick();
    load_data = 32'hCAFE_0001;
    mdl[101] = load_data;
    tick();
    chk("abort_sum", checksum, 32'hCAFE_0000 + 32'hCAFE_0001);
    load_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk_rst("abort");
    reset = 1'b1;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    drain_to_run("abort");
    fetch(100);
    fetch(101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
